// File: rtl/id_ex_ctrl_stage.sv
// ID-stage control decode with the ID/EX pipeline register, load-use hazard
// detection (one-cycle bubble plus stall) and branch-flush bubble insertion.
module id_ex_ctrl_stage #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] instr_i,
    input  logic              valid_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              valid_o,
    output logic [2:0]        ALUOp_o,
    output logic [5:0]        funct_o,
    output logic              RegWrite_o,
    output logic              ALUSrc_o,
    output logic              RegDst_o,
    output logic              Branch_o,
    output logic              MemRead_o,
    output logic              MemWrite_o,
    output logic              MemtoReg_o,
    output logic [4:0]        rs_o,
    output logic [4:0]        rt_o,
    output logic [4:0]        rd_o,
    output logic [DATA_W-1:0] imm_o,
    output logic              illegal_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [5:0]        w_opcode;
    logic [2:0]        w_alu_op;
    logic              w_reg_write, w_alu_src, w_reg_dst, w_branch;
    logic              w_mem_read, w_mem_write, w_mem_to_reg;
    logic              w_uses_rt, w_illegal;
    logic              w_stall, w_load;
    logic [DATA_W-1:0] w_imm;

    logic              r_valid;
    logic [2:0]        r_alu_op;
    logic [5:0]        r_funct;
    logic              r_reg_write, r_alu_src, r_reg_dst, r_branch;
    logic              r_mem_read, r_mem_write, r_mem_to_reg;
    logic [4:0]        r_rs, r_rt, r_rd;
    logic [DATA_W-1:0] r_imm;
    logic              r_illegal;
    logic [CNT_W-1:0]  r_stall_cnt;

    assign w_opcode = instr_i[31:26];
    assign w_imm    = {{(DATA_W-16){instr_i[15]}}, instr_i[15:0]};

    // Opcode decode into ALUOp, datapath controls and hazard-relevant flags.
    always_comb begin
        w_alu_op     = 3'd0;
        w_reg_write  = 1'b0;
        w_alu_src    = 1'b0;
        w_reg_dst    = 1'b0;
        w_branch     = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_uses_rt    = 1'b0;
        w_illegal    = 1'b0;
        case (w_opcode)
            OP_RTYPE: begin
                w_alu_op    = 3'd1;
                w_reg_write = 1'b1;
                w_reg_dst   = 1'b1;
                w_uses_rt   = 1'b1;
            end
            OP_ADDI: begin
                w_alu_op    = 3'd2;
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            OP_SLTI: begin
                w_alu_op    = 3'd3;
                w_reg_write = 1'b1;
                w_alu_src   = 1'b1;
            end
            OP_BEQ: begin
                w_alu_op  = 3'd4;
                w_branch  = 1'b1;
                w_uses_rt = 1'b1;
            end
            OP_LW: begin
                w_alu_op     = 3'd5;
                w_reg_write  = 1'b1;
                w_alu_src    = 1'b1;
                w_mem_read   = 1'b1;
                w_mem_to_reg = 1'b1;
            end
            OP_SW: begin
                w_alu_op    = 3'd6;
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
                w_uses_rt   = 1'b1;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    // Load-use hazard: the load in EX writes a register the ID instruction reads ($0 exempt).
    assign w_stall = valid_i & ~flush_i & r_mem_read & r_valid & (r_rt != 5'd0) &
                     ((r_rt == instr_i[25:21]) | (w_uses_rt & (r_rt == instr_i[20:16])));

    assign w_load = valid_i & ~flush_i & ~w_stall;

    // ID/EX register: bubble on flush, stall or empty slot; otherwise capture decode.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid      <= 1'b0;
            r_alu_op     <= 3'd0;
            r_funct      <= 6'd0;
            r_reg_write  <= 1'b0;
            r_alu_src    <= 1'b0;
            r_reg_dst    <= 1'b0;
            r_branch     <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_rs         <= 5'd0;
            r_rt         <= 5'd0;
            r_rd         <= 5'd0;
            r_imm        <= {DATA_W{1'b0}};
            r_illegal    <= 1'b0;
        end else begin
            r_funct <= instr_i[5:0];
            r_rs    <= instr_i[25:21];
            r_rt    <= instr_i[20:16];
            r_rd    <= instr_i[15:11];
            r_imm   <= w_imm;
            if (w_load) begin
                r_valid      <= 1'b1;
                r_alu_op     <= w_alu_op;
                r_reg_write  <= w_reg_write;
                r_alu_src    <= w_alu_src;
                r_reg_dst    <= w_reg_dst;
                r_branch     <= w_branch;
                r_mem_read   <= w_mem_read;
                r_mem_write  <= w_mem_write;
                r_mem_to_reg <= w_mem_to_reg;
                r_illegal    <= w_illegal;
            end else begin
                r_valid      <= 1'b0;
                r_alu_op     <= 3'd0;
                r_reg_write  <= 1'b0;
                r_alu_src    <= 1'b0;
                r_reg_dst    <= 1'b0;
                r_branch     <= 1'b0;
                r_mem_read   <= 1'b0;
                r_mem_write  <= 1'b0;
                r_mem_to_reg <= 1'b0;
                r_illegal    <= 1'b0;
            end
        end
    end

    // Saturating count of stall cycles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= {CNT_W{1'b0}};
        end else if (w_stall && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign stall_o     = w_stall;
    assign valid_o     = r_valid;
    assign ALUOp_o     = r_alu_op;
    assign funct_o     = r_funct;
    assign RegWrite_o  = r_reg_write;
    assign ALUSrc_o    = r_alu_src;
    assign RegDst_o    = r_reg_dst;
    assign Branch_o    = r_branch;
    assign MemRead_o   = r_mem_read;
    assign MemWrite_o  = r_mem_write;
    assign MemtoReg_o  = r_mem_to_reg;
    assign rs_o        = r_rs;
    assign rt_o        = r_rt;
    assign rd_o        = r_rd;
    assign imm_o       = r_imm;
    assign illegal_o   = r_illegal;
    assign stall_cnt_o = r_stall_cnt;

endmodule
